// File: rtl/decode_stage.sv
// RV32I decode/operand-read stage: regfile read-port steering, immediate and control decode,
// and a valid/ready output register. Define DECODE_SCOREBOARD_EN to build the RAW-hazard scoreboard.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_fetch_valid,
    output logic            out_fetch_ready,
    input  logic [31:0]     in_fetch_instr,
    input  logic [XLEN-1:0] in_fetch_pc,
    output logic [4:0]      out_reg_number_1,
    output logic [4:0]      out_reg_number_2,
    input  logic [XLEN-1:0] in_reg_value_1,
    input  logic [XLEN-1:0] in_reg_value_2,
    input  logic            in_wb_enable,
    input  logic [4:0]      in_wb_number,
    input  logic            in_flush,
    output logic            out_valid,
    input  logic            in_exec_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_value,
    output logic [XLEN-1:0] out_rs2_value,
    output logic [XLEN-1:0] out_imm,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7_5,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0]     instr_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [4:0]      rd_s;
    logic            rs1_used_s;
    logic            rs2_used_s;
    logic            rd_wr_s;
    logic            illegal_s;
    logic [XLEN-1:0] imm_s;
    logic            hazard_s;
    logic            ready_s;
    logic            issue_s;

    logic            valid_q,   valid_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic [XLEN-1:0] rs1_val_q, rs1_val_d;
    logic [XLEN-1:0] rs2_val_q, rs2_val_d;
    logic [XLEN-1:0] imm_q,     imm_d;
    logic [6:0]      opcode_q,  opcode_d;
    logic [2:0]      funct3_q,  funct3_d;
    logic            f7_5_q,    f7_5_d;
    logic [4:0]      rd_q,      rd_d;
    logic            illegal_q, illegal_d;

    assign instr_s          = in_fetch_instr;
    assign rs1_s            = instr_s[19:15];
    assign rs2_s            = instr_s[24:20];
    assign out_reg_number_1 = rs1_s;
    assign out_reg_number_2 = rs2_s;

    // Opcode decode: source/destination usage and immediate format.
    always_comb begin
        rs1_used_s = 1'b0;
        rs2_used_s = 1'b0;
        rd_wr_s    = 1'b0;
        illegal_s  = 1'b0;
        imm_s      = 32'd0;
        case (instr_s[6:0])
            OPC_LUI, OPC_AUIPC: begin
                rd_wr_s = 1'b1;
                imm_s   = {instr_s[31:12], 12'd0};
            end
            OPC_JAL: begin
                rd_wr_s = 1'b1;
                imm_s   = {{12{instr_s[31]}}, instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                rs1_used_s = 1'b1;
                rd_wr_s    = 1'b1;
                imm_s      = {{20{instr_s[31]}}, instr_s[31:20]};
            end
            OPC_BRANCH: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b1;
                imm_s      = {{20{instr_s[31]}}, instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
            end
            OPC_STORE: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b1;
                imm_s      = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
            end
            OPC_OP: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b1;
                rd_wr_s    = 1'b1;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    assign rd_s = rd_wr_s ? instr_s[11:7] : 5'd0;

`ifdef DECODE_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;
    logic [31:0] wb_clr_s;
    logic [31:0] busy_eff_s;

    // Writeback retire mask; a retiring register is no longer a hazard this cycle.
    always_comb begin
        wb_clr_s = 32'd0;
        if (in_wb_enable && (in_wb_number != 5'd0)) begin
            wb_clr_s[in_wb_number] = 1'b1;
        end else begin
            wb_clr_s = 32'd0;
        end
    end

    assign busy_eff_s = busy_q & ~wb_clr_s;
    assign hazard_s   = (rs1_used_s && busy_eff_s[rs1_s]) || (rs2_used_s && busy_eff_s[rs2_s]);

    // Scoreboard next state: flush clears all, an issue's set beats a same-register retire.
    always_comb begin
        busy_d = busy_eff_s;
        if (in_flush) begin
            busy_d = 32'd0;
        end else if (issue_s && (rd_s != 5'd0)) begin
            busy_d[rd_s] = 1'b1;
        end else begin
            busy_d = busy_eff_s;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end
`else
    logic unused_wb_s;
    assign unused_wb_s = ^{in_wb_enable, in_wb_number};
    assign hazard_s    = 1'b0;
`endif

    assign ready_s         = !hazard_s && !in_flush && (!valid_q || in_exec_ready);
    assign issue_s         = in_fetch_valid && ready_s;
    assign out_fetch_ready = ready_s;

    // Output register next state: load on issue, drain on consume, hold on stall.
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        imm_d     = imm_q;
        opcode_d  = opcode_q;
        funct3_d  = funct3_q;
        f7_5_d    = f7_5_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
        if (in_flush) begin
            valid_d = 1'b0;
        end else if (issue_s) begin
            valid_d   = 1'b1;
            pc_d      = in_fetch_pc;
            rs1_val_d = in_reg_value_1;
            rs2_val_d = in_reg_value_2;
            imm_d     = imm_s;
            opcode_d  = instr_s[6:0];
            funct3_d  = instr_s[14:12];
            f7_5_d    = instr_s[30];
            rd_d      = rd_s;
            illegal_d = illegal_s;
        end else if (valid_q && in_exec_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= 32'd0;
            rs1_val_q <= 32'd0;
            rs2_val_q <= 32'd0;
            imm_q     <= 32'd0;
            opcode_q  <= 7'd0;
            funct3_q  <= 3'd0;
            f7_5_q    <= 1'b0;
            rd_q      <= 5'd0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            imm_q     <= imm_d;
            opcode_q  <= opcode_d;
            funct3_q  <= funct3_d;
            f7_5_q    <= f7_5_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = pc_q;
    assign out_rs1_value = rs1_val_q;
    assign out_rs2_value = rs2_val_q;
    assign out_imm       = imm_q;
    assign out_opcode    = opcode_q;
    assign out_funct3    = funct3_q;
    assign out_funct7_5  = f7_5_q;
    assign out_rd        = rd_q;
    assign out_illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table of decoded vectors, scoreboard queue of
// expected outputs, and hand sequences for hazard, stall, flush and asynchronous reset.
module tb_decode_stage;

`ifdef DECODE_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_fetch_valid;
    logic        out_fetch_ready;
    logic [31:0] in_fetch_instr;
    logic [31:0] in_fetch_pc;
    logic [4:0]  out_reg_number_1;
    logic [4:0]  out_reg_number_2;
    logic [31:0] in_reg_value_1;
    logic [31:0] in_reg_value_2;
    logic        in_wb_enable;
    logic [4:0]  in_wb_number;
    logic        in_flush;
    logic        out_valid;
    logic        in_exec_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_value;
    logic [31:0] out_rs2_value;
    logic [31:0] out_imm;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7_5;
    logic [4:0]  out_rd;
    logic        out_illegal;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .in_fetch_valid(in_fetch_valid), .out_fetch_ready(out_fetch_ready),
        .in_fetch_instr(in_fetch_instr), .in_fetch_pc(in_fetch_pc),
        .out_reg_number_1(out_reg_number_1), .out_reg_number_2(out_reg_number_2),
        .in_reg_value_1(in_reg_value_1), .in_reg_value_2(in_reg_value_2),
        .in_wb_enable(in_wb_enable), .in_wb_number(in_wb_number),
        .in_flush(in_flush), .out_valid(out_valid), .in_exec_ready(in_exec_ready),
        .out_pc(out_pc), .out_rs1_value(out_rs1_value), .out_rs2_value(out_rs2_value),
        .out_imm(out_imm), .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7_5(out_funct7_5), .out_rd(out_rd), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    vec_t        q[$];
    vec_t        tbl[13];
    vec_t        mon_e;
    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] pc_ctr  = 32'h0000_1000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] imm,
                                input logic [4:0] rd, input logic ill);
        vec_t v;
        v.instr = instr; v.pc = 32'h0; v.v1 = $urandom; v.v2 = $urandom;
        v.imm = imm; v.rd = rd; v.ill = ill;
        return v;
    endfunction

    // Present one instruction; if accepted, its expected output joins the queue.
    task automatic present(input string nm, input vec_t v, input logic exp_rdy);
        v.pc = pc_ctr;
        pc_ctr = pc_ctr + 32'd4;
        next_cyc();
        in_fetch_valid = 1'b1;
        in_fetch_instr = v.instr;
        in_fetch_pc    = v.pc;
        in_reg_value_1 = v.v1;
        in_reg_value_2 = v.v2;
        @(negedge clk);
        chk({nm, "_ready"}, 32'(out_fetch_ready), 32'(exp_rdy));
        if (out_fetch_ready) q.push_back(v);
    endtask

    // Output monitor: every consumed output is compared against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && in_exec_ready) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got pc %h expected no output", out_pc);
            end else begin
                mon_e = q.pop_front();
                chk("pc",      out_pc,        mon_e.pc);
                chk("rs1_val", out_rs1_value, mon_e.v1);
                chk("rs2_val", out_rs2_value, mon_e.v2);
                chk("imm",     out_imm,       mon_e.imm);
                chk("opcode",  32'(out_opcode),   32'(mon_e.instr[6:0]));
                chk("funct3",  32'(out_funct3),   32'(mon_e.instr[14:12]));
                chk("funct7_5", 32'(out_funct7_5), 32'(mon_e.instr[30]));
                chk("rd",      32'(out_rd),       32'(mon_e.rd));
                chk("illegal", 32'(out_illegal),  32'(mon_e.ill));
            end
        end
    end

    vec_t p_v, s_v;
    logic [31:0] p_pc;

    initial begin
        rst = 1'b1;
        in_fetch_valid = 1'b0; in_fetch_instr = 32'd0; in_fetch_pc = 32'd0;
        in_reg_value_1 = 32'd0; in_reg_value_2 = 32'd0;
        in_wb_enable = 1'b0; in_wb_number = 5'd0; in_flush = 1'b0; in_exec_ready = 1'b1;

        tbl[0]  = mk(32'h00500093, 32'h00000005, 5'd1,  1'b0); // ADDI x1,x0,5
        tbl[1]  = mk(32'hABCDE2B7, 32'hABCDE000, 5'd5,  1'b0); // LUI
        tbl[2]  = mk(32'h12345317, 32'h12345000, 5'd6,  1'b0); // AUIPC
        tbl[3]  = mk(32'h001003EF, 32'h00000800, 5'd7,  1'b0); // JAL +2048
        tbl[4]  = mk(32'hFFFFF46F, 32'hFFFFFFFE, 5'd8,  1'b0); // JAL -2
        tbl[5]  = mk(32'hFE000CE3, 32'hFFFFFFF8, 5'd0,  1'b0); // BEQ -8
        tbl[6]  = mk(32'hFE902E23, 32'hFFFFFFFC, 5'd0,  1'b0); // SW x9,-4(x0)
        tbl[7]  = mk(32'h01002503, 32'h00000010, 5'd10, 1'b0); // LW x10,16(x0)
        tbl[8]  = mk(32'hFFF005E7, 32'hFFFFFFFF, 5'd11, 1'b0); // JALR x11,-1(x0)
        tbl[9]  = mk(32'h40000633, 32'h00000000, 5'd12, 1'b0); // SUB
        tbl[10] = mk(32'h0000007F, 32'h00000000, 5'd0,  1'b1); // illegal
        tbl[11] = mk(32'hFFFFFFFF, 32'h00000000, 5'd0,  1'b1); // illegal, rd field 31
        tbl[12] = mk(32'h01FC86B3, 32'h00000000, 5'd13, 1'b0); // ADD x13,x25,x31: BEQ/illegal left no busy bits

        #12;
        chk("rst_hold_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(out_fetch_ready), 32'd1);
        chk("rst_data", out_pc | out_rs1_value | out_rs2_value | out_imm |
            {15'd0, out_opcode, out_funct3, out_funct7_5, out_rd, out_illegal}, 32'd0);

        for (int i = 0; i < 13; i++) present($sformatf("tbl%0d", i), tbl[i], 1'b1);
        next_cyc();
        in_fetch_valid = 1'b0;

        // Flush with busy[3], busy[5] pending and out_valid high.
        present("addi_x3", mk(32'h00100193, 32'h1, 5'd3, 1'b0), 1'b1);
        present("addi_x5", mk(32'h00200293, 32'h2, 5'd5, 1'b0), 1'b1);
        next_cyc();
        in_fetch_instr = 32'h00518233;
        in_flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", 32'(out_fetch_ready), 32'd0);
        next_cyc();
        in_flush = 1'b0;
        in_fetch_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(out_valid), 32'd0);
        present("add_after_flush", mk(32'h00518233, 32'h0, 5'd4, 1'b0), 1'b1);

        // RAW hazard on x1, retire forwarding, and set-beats-retire.
        present("hz_addi", mk(32'h00500093, 32'h5, 5'd1, 1'b0), 1'b1);
        in_wb_enable = 1'b1; in_wb_number = 5'd0;
        present("hz_stall_wb0", mk(32'h00108133, 32'h0, 5'd2, 1'b0), !SB_EN);
        in_wb_number = 5'd1;
        s_v = mk(32'h00108133, 32'h0, 5'd2, 1'b0);
        s_v.v1 = 32'h12345678; s_v.v2 = 32'h12345678;
        present("hz_wb_issue", s_v, 1'b1);
        present("hz_set_wins", mk(32'h00700093, 32'h7, 5'd1, 1'b0), 1'b1);
        in_wb_number = 5'd2;
        present("hz_still_busy", mk(32'h00108133, 32'h0, 5'd2, 1'b0), !SB_EN);
        in_wb_number = 5'd1;
        present("hz_release", mk(32'h00108133, 32'h0, 5'd2, 1'b0), 1'b1);
        next_cyc();
        in_wb_enable = 1'b0;
        in_fetch_valid = 1'b0;

        // Back-pressure: three stalled cycles hold every output.
        p_pc = pc_ctr;
        p_v  = mk(32'hABCDE2B7, 32'hABCDE000, 5'd5, 1'b0);
        present("stall_p", p_v, 1'b1);
        p_v  = q[q.size() - 1];
        s_v  = mk(32'h12345317, 32'h12345000, 5'd6, 1'b0);
        s_v.pc = pc_ctr;
        pc_ctr = pc_ctr + 32'd4;
        next_cyc();
        in_exec_ready  = 1'b0;
        in_fetch_instr = s_v.instr;
        in_fetch_pc    = s_v.pc;
        in_reg_value_1 = s_v.v1;
        in_reg_value_2 = s_v.v2;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_ready", 32'(out_fetch_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_pc",    out_pc, p_pc);
            chk("stall_imm",   out_imm, 32'hABCDE000);
            chk("stall_rs1",   out_rs1_value, p_v.v1);
            chk("stall_rd",    32'(out_rd), 32'd5);
            next_cyc();
        end
        in_exec_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_ready", 32'(out_fetch_ready), 32'd1);
        if (out_fetch_ready) q.push_back(s_v);
        next_cyc();
        in_fetch_valid = 1'b0;

        // Asynchronous reset mid-operation.
        present("pre_rst", mk(32'h00500093, 32'h5, 5'd1, 1'b0), 1'b1);
        next_cyc();
        in_fetch_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        present("post_rst_add", mk(32'h00108133, 32'h0, 5'd2, 1'b0), 1'b1);
        next_cyc();
        in_fetch_valid = 1'b0;

        repeat (3) next_cyc();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
